pong_game: RTL and testbench

Game-state engine for the 16x16 dot-matrix pong. Generates the game tick, moves the ball, bounces it off walls and paddles, moves both paddles from button inputs, and keeps score. Sits directly upstream of the matrix scan driver: its x, y, lpaddle and rpaddle outputs feed that driver unchanged. Coordinates are in half-pixel units; the driver displays x[4:1], y[4:1] and the even paddle bits only.

---
 rtl/pong_game.sv | 178 +++++++++++++++++
 tb/tb_pong_game.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pong_game.sv
// Game-state engine for the 16x16 dot-matrix pong: tick generation, ball motion,
// paddle control and scoring, all in half-pixel coordinates.
module pong_game #(
  parameter int TICKWIDTH   = 18,
  parameter int PADDLE_LEN  = 6,
  parameter int SERVE_TICKS = 32,
  parameter int WIN_SCORE   = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lup,
  input  logic        ldn,
  input  logic        rup,
  input  logic        rdn,
  input  logic        start,
  output logic [4:0]  x,
  output logic [4:0]  y,
  output logic [31:0] lpaddle,
  output logic [31:0] rpaddle,
  output logic [3:0]  lscore,
  output logic [3:0]  rscore,
  output logic        playing
);

  localparam int TIMER_W = $clog2(SERVE_TICKS + 1);
  localparam logic [4:0] MAX_POS = 5'(32 - PADDLE_LEN);
  localparam logic [31:0] PAD_MASK = (32'd1 << PADDLE_LEN) - 32'd1;
  localparam logic [TICKWIDTH-1:0] CNT_ONE = 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SERVE_TICKS - 1);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  typedef enum logic [1:0] {SERVE, PLAY, SCORE, OVER} state_t;

  state_t               r_state;
  logic [TICKWIDTH-1:0] r_cnt;
  logic [TIMER_W-1:0]   r_timer;
  logic [4:0]           r_sync1, r_sync2;
  logic [4:0]           r_x, r_y, r_lpos, r_rpos;
  logic                 r_dxNeg, r_dyNeg, r_serveDyNeg;
  logic [31:0]          r_lpaddle, r_rpaddle;
  logic [3:0]           r_lscore, r_rscore;
  logic                 r_playing;

  logic       w_tick;
  logic [4:0] w_lposNext, w_rposNext;

  function automatic logic [4:0] nextPos(input logic [4:0] pos, input logic up, input logic dn);
    nextPos = pos;
    if (up && !dn)
      nextPos = (pos <= 5'd2) ? 5'd0 : pos - 5'd2;
    else if (dn && !up)
      nextPos = (pos >= MAX_POS - 5'd2) ? MAX_POS : pos + 5'd2;
  endfunction

  assign w_tick     = &r_cnt;
  assign w_lposNext = nextPos(r_lpos, r_sync2[0], r_sync2[1]);
  assign w_rposNext = nextPos(r_rpos, r_sync2[2], r_sync2[3]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= SERVE;
      r_cnt        <= '0;
      r_timer      <= '0;
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_x          <= 5'd16;
      r_y          <= 5'd16;
      r_dxNeg      <= 1'b0;
      r_dyNeg      <= 1'b0;
      r_serveDyNeg <= 1'b0;
      r_lpos       <= 5'd12;
      r_rpos       <= 5'd12;
      r_lpaddle    <= PAD_MASK << 12;
      r_rpaddle    <= PAD_MASK << 12;
      r_lscore     <= '0;
      r_rscore     <= '0;
      r_playing    <= 1'b0;
    end else begin
      r_cnt   <= r_cnt + CNT_ONE;
      r_sync1 <= {start, rdn, rup, ldn, lup};
      r_sync2 <= r_sync1;
      if (w_tick) begin
        r_lpos    <= w_lposNext;
        r_rpos    <= w_rposNext;
        r_lpaddle <= PAD_MASK << w_lposNext;
        r_rpaddle <= PAD_MASK << w_rposNext;
        case (r_state)
          SERVE: begin
            r_x <= 5'd16;
            r_y <= 5'd16;
            if (r_timer == TIMER_LAST) begin
              r_timer   <= '0;
              r_state   <= PLAY;
              r_playing <= 1'b1;
            end else begin
              r_timer <= r_timer + TIMER_W'(1);
            end
          end
          PLAY: begin
            // Hit tests use the paddle bitmaps and y from before this tick.
            if (r_y == 5'd31 && !r_dyNeg) begin
              r_y     <= 5'd30;
              r_dyNeg <= 1'b1;
            end else if (r_y == 5'd0 && r_dyNeg) begin
              r_y     <= 5'd1;
              r_dyNeg <= 1'b0;
            end else begin
              r_y <= r_dyNeg ? r_y - 5'd1 : r_y + 5'd1;
            end
            if (r_x == 5'd29 && !r_dxNeg) begin
              if (r_lpaddle[r_y]) begin
                r_x     <= 5'd28;
                r_dxNeg <= 1'b1;
              end else begin
                r_x       <= 5'd30;
                r_rscore  <= r_rscore + 4'd1;
                r_state   <= SCORE;
                r_playing <= 1'b0;
              end
            end else if (r_x == 5'd2 && r_dxNeg) begin
              if (r_rpaddle[r_y]) begin
                r_x     <= 5'd3;
                r_dxNeg <= 1'b0;
              end else begin
                r_x       <= 5'd1;
                r_lscore  <= r_lscore + 4'd1;
                r_state   <= SCORE;
                r_playing <= 1'b0;
              end
            end else begin
              r_x <= r_dxNeg ? r_x - 5'd1 : r_x + 5'd1;
            end
          end
          SCORE: begin
            // dx is left as it was at the miss, so it already points at the conceder.
            if (r_timer == TIMER_LAST) begin
              r_timer <= '0;
              if (r_lscore == WIN || r_rscore == WIN) begin
                r_state <= OVER;
              end else begin
                r_state      <= SERVE;
                r_x          <= 5'd16;
                r_y          <= 5'd16;
                r_dyNeg      <= !r_serveDyNeg;
                r_serveDyNeg <= !r_serveDyNeg;
              end
            end else begin
              r_timer <= r_timer + TIMER_W'(1);
            end
          end
          OVER: begin
            if (r_sync2[4]) begin
              r_state      <= SERVE;
              r_timer      <= '0;
              r_lscore     <= '0;
              r_rscore     <= '0;
              r_x          <= 5'd16;
              r_y          <= 5'd16;
              r_dxNeg      <= 1'b0;
              r_dyNeg      <= 1'b0;
              r_serveDyNeg <= 1'b0;
            end
          end
          default: r_state <= SERVE;
        endcase
      end
    end
  end

  assign x       = r_x;
  assign y       = r_y;
  assign lpaddle = r_lpaddle;
  assign rpaddle = r_rpaddle;
  assign lscore  = r_lscore;
  assign rscore  = r_rscore;
  assign playing = r_playing;

endmodule

// File: tb/tb_pong_game.sv
// Directed bench for pong_game with a 4-cycle tick and 2-tick serve/score pauses,
// walking one full game from reset through OVER, restart and a mid-play reset.
module tb_pong_game;

  logic        clk = 1'b0;
  logic        reset;
  logic        lup, ldn, rup, rdn, start;
  logic [4:0]  x, y;
  logic [31:0] lpaddle, rpaddle;
  logic [3:0]  lscore, rscore;
  logic        playing;

  int errorCount = 0;
  int checkCount = 0;
  int tickNo = 0;

  pong_game #(.TICKWIDTH(2), .PADDLE_LEN(6), .SERVE_TICKS(2), .WIN_SCORE(9)) dut (
    .clk(clk), .reset(reset),
    .lup(lup), .ldn(ldn), .rup(rup), .rdn(rdn), .start(start),
    .x(x), .y(y), .lpaddle(lpaddle), .rpaddle(rpaddle),
    .lscore(lscore), .rscore(rscore), .playing(playing)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (tick %0d)", tag, observed, expected, tickNo);
    end
  endtask

  // One tick is four clk edges; sample 1 ns after the tick edge.
  task automatic runToTick(input int target);
    while (tickNo < target) begin
      repeat (4) @(posedge clk);
      #1;
      tickNo++;
    end
  endtask

  initial begin
    reset = 1'b1;
    {lup, ldn, rup, rdn, start} = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_x", 32'(x), 32'd16);
    checkOutput("rst_y", 32'(y), 32'd16);
    checkOutput("rst_lpad", lpaddle, 32'h0003F000);
    checkOutput("rst_rpad", rpaddle, 32'h0003F000);
    checkOutput("rst_lscore", 32'(lscore), 32'd0);
    checkOutput("rst_rscore", 32'(rscore), 32'd0);
    checkOutput("rst_playing", 32'(playing), 32'd0);

    ldn = 1'b1;
    runToTick(1);
    checkOutput("ldn_t1", lpaddle, 32'h000FC000);
    checkOutput("serve_t1", 32'(playing), 32'd0);
    runToTick(2);
    checkOutput("play_rise", 32'(playing), 32'd1);
    checkOutput("serve_x", 32'(x), 32'd16);
    runToTick(3);
    checkOutput("first_x", 32'(x), 32'd17);
    checkOutput("first_y", 32'(y), 32'd17);
    runToTick(7);
    checkOutput("ldn_bottom", lpaddle, 32'hFC000000);
    runToTick(10);
    checkOutput("ldn_clamp", lpaddle, 32'hFC000000);
    ldn = 1'b0;

    runToTick(15);
    checkOutput("pre_hit_x", 32'(x), 32'd29);
    checkOutput("pre_hit_y", 32'(y), 32'd29);
    runToTick(16);
    checkOutput("hit_x", 32'(x), 32'd28);
    checkOutput("hit_y", 32'(y), 32'd30);
    checkOutput("hit_rscore", 32'(rscore), 32'd0);
    checkOutput("hit_playing", 32'(playing), 32'd1);
    runToTick(17);
    checkOutput("wall_pre_y", 32'(y), 32'd31);
    runToTick(18);
    checkOutput("wall_y", 32'(y), 32'd30);
    checkOutput("wall_x", 32'(x), 32'd26);
    runToTick(42);
    checkOutput("pre_miss_x", 32'(x), 32'd2);
    checkOutput("pre_miss_y", 32'(y), 32'd6);
    runToTick(43);
    checkOutput("miss_x", 32'(x), 32'd1);
    checkOutput("miss_y", 32'(y), 32'd5);
    checkOutput("miss_lscore", 32'(lscore), 32'd1);
    checkOutput("miss_rscore", 32'(rscore), 32'd0);
    checkOutput("miss_playing", 32'(playing), 32'd0);
    runToTick(44);
    checkOutput("score_frozen", 32'(x), 32'd1);
    runToTick(45);
    checkOutput("reserve_x", 32'(x), 32'd16);
    checkOutput("reserve_y", 32'(y), 32'd16);

    lup = 1'b1;
    runToTick(47);
    checkOutput("play2_rise", 32'(playing), 32'd1);
    runToTick(48);
    checkOutput("serve2_x", 32'(x), 32'd15);
    checkOutput("serve2_y", 32'(y), 32'd15);
    runToTick(60);
    checkOutput("lup_top", lpaddle, 32'h0000003F);
    lup = 1'b0;
    ldn = 1'b1;
    runToTick(62);
    checkOutput("ldn_from_top", lpaddle, 32'h000003F0);
    checkOutput("miss2_y", 32'(y), 32'd1);
    checkOutput("miss2_lscore", 32'(lscore), 32'd2);
    lup = 1'b1;
    runToTick(64);
    checkOutput("both_hold", lpaddle, 32'h000003F0);
    lup = 1'b0;
    ldn = 1'b0;

    runToTick(81);
    checkOutput("miss3_x", 32'(x), 32'd1);
    checkOutput("miss3_y", 32'(y), 32'd31);
    checkOutput("miss3_lscore", 32'(lscore), 32'd3);
    runToTick(195);
    checkOutput("miss9_lscore", 32'(lscore), 32'd9);
    checkOutput("miss9_y", 32'(y), 32'd31);
    checkOutput("miss9_rpad", rpaddle, 32'h0003F000);
    runToTick(200);
    checkOutput("over_x", 32'(x), 32'd1);
    checkOutput("over_y", 32'(y), 32'd31);
    checkOutput("over_lscore", 32'(lscore), 32'd9);
    checkOutput("over_playing", 32'(playing), 32'd0);

    start = 1'b1;
    runToTick(201);
    checkOutput("restart_lscore", 32'(lscore), 32'd0);
    checkOutput("restart_x", 32'(x), 32'd16);
    checkOutput("restart_y", 32'(y), 32'd16);
    start = 1'b0;
    runToTick(203);
    checkOutput("restart_play", 32'(playing), 32'd1);
    runToTick(204);
    checkOutput("restart_dx", 32'(x), 32'd17);
    checkOutput("restart_dy", 32'(y), 32'd17);

    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_x", 32'(x), 32'd16);
    checkOutput("async_y", 32'(y), 32'd16);
    checkOutput("async_lpad", lpaddle, 32'h0003F000);
    checkOutput("async_playing", 32'(playing), 32'd0);
    #10;
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
